mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, max cycles waiting for memory response; 0 disables timeout.
REQ-002 SHALL have ports: i_clk  in  1  global clock, rising edge.
REQ-003 SHALL have i_rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have fetch requester ports: i_if_req in 1 (request); i_if_addr in 32 (word-aligned address); o_if_ready out 1 (request accepted); o_if_valid out 1 (response); o_if_rdata out 32 (fetched word); o_if_err out 1 (timeout).
REQ-005 SHALL have data requester ports: i_d_req in 1 (request); i_d_wen in 1 (1=store, 0=load); i_d_addr in 32 (aligned address); i_d_wdata in 32 (store data); i_d_mask in 4 (byte lanes); o_d_ready out 1 (accepted); o_d_valid out 1 (response); o_d_rdata out 32 (load data); o_d_err out 1 (timeout).
REQ-006 SHALL have memory ports: o_mem_req out 1; o_mem_wen out 1; o_mem_addr out 32; o_mem_wdata out 32; o_mem_mask out 4; i_mem_ready in 1 (request taken); i_mem_valid in 1 (response/write ack); i_mem_rdata in 32.

Function
REQ-007 SHALL share one memory port between fetch and data requesters, at most one transaction outstanding.
REQ-008 SHALL implement FSM IDLE -> ISSUE -> WAIT -> IDLE, with a registered owner (FETCH/DATA).
REQ-009 In IDLE with any request, SHALL grant one requester, pulse its o_*_ready for exactly that cycle, register its address/wdata/mask/wen, enter ISSUE.
REQ-010 SHALL never assert o_if_ready and o_d_ready in the same cycle; no ready outside IDLE.
REQ-011 In ISSUE, SHALL drive o_mem_req=1 and registered fields, stable until i_mem_ready=1 at a rising edge, then enter WAIT.
REQ-012 Fetch grants SHALL drive o_mem_wen=0 and o_mem_mask=4'b1111.
REQ-013 In ISSUE, i_mem_ready=1 together with i_mem_valid=1 SHALL complete the transaction directly (zero-latency memory), skipping WAIT.
REQ-014 In WAIT, i_mem_valid=1 SHALL register i_mem_rdata to owner's o_*_rdata and pulse owner's o_*_valid one cycle later, then return to IDLE.
REQ-015 Store responses SHALL drive o_d_rdata=0.
REQ-016 i_mem_valid in IDLE SHALL be ignored.
REQ-017 Minimum latency: ready pulse cycle N, o_mem_req cycle N+1, o_*_valid cycle N+2 for zero-latency memory.
REQ-018 Grant in the same cycle as the previous o_*_valid pulse SHALL be permitted (back-to-back, one transaction per 2 cycles minimum).
REQ-019 WAIT cycle counter SHALL reset on WAIT entry; on reaching TIMEOUT_CYCLES, SHALL pulse owner's o_*_valid with o_*_err=1, rdata=0, return to IDLE; a later stray i_mem_valid is ignored.
REQ-020 o_*_valid, o_*_err SHALL be single-cycle pulses; o_*_rdata holds until next response.

Reset
REQ-021 Asserting i_rst SHALL immediately force IDLE, owner FETCH, counter 0, all outputs 0.
REQ-022 Reset mid-transaction SHALL drop it with no response; memory-side response after release is ignored.

Configuration
REQ-023 With MEM_ARBITER_ROUND_ROBIN_EN defined, IDLE arbitration SHALL be round-robin: on contention, grant the requester not granted last; pointer resets to favour DATA.
REQ-024 Without MEM_ARBITER_ROUND_ROBIN_EN, arbitration SHALL be fixed priority: DATA over FETCH.

Structure
REQ-025 Shared package mem_arb_pkg SHALL hold FSM state enum, owner encoding (OWN_FETCH, OWN_DATA) and default TIMEOUT_CYCLES constant.
REQ-026 Grant selection SHALL be a combinational sub-module mem_arb_prio (inputs: both requests, last-owner; output: grant one-hot).

Verification
REQ-027 Fetch only, addr 0x100, memory ready/valid same cycle, rdata 0x00100073 -> o_if_ready cycle N, o_mem_req N+1, o_if_valid N+2 with 0x00100073.
REQ-028 Both request same cycle (load 0x2000, fetch 0x04) -> DATA granted first; FETCH granted after o_d_valid; round-robin build: sustained contention alternates D,F,D,F.
REQ-029 Store 0x2003 mask 4'b1000 wdata 0xAB000000, i_mem_ready delayed 3 cycles -> o_mem_* stable all 3 cycles, o_d_valid with o_d_rdata=0.
REQ-030 TIMEOUT_CYCLES=4, load never answered -> o_d_valid=1 and o_d_err=1 after 4 WAIT cycles, late i_mem_valid ignored.
REQ-031 i_rst asserted during WAIT -> all outputs 0 immediately, no o_*_valid, next request served normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state, owner and timing constants for mem_arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_e;

    // Registered owner of the single outstanding memory transaction
    localparam logic OWN_FETCH = 1'b0;
    localparam logic OWN_DATA  = 1'b1;

    // One-hot grant vector: bit 0 fetch, bit 1 data
    localparam logic [1:0] GNT_NONE  = 2'b00;
    localparam logic [1:0] GNT_FETCH = 2'b01;
    localparam logic [1:0] GNT_DATA  = 2'b10;

    localparam int DEFAULT_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/mem_arb_prio.sv
// rtl/mem_arb_prio.sv - grant select; MEM_ARBITER_ROUND_ROBIN_EN enables round-robin
module mem_arb_prio
    import mem_arb_pkg::*;
(
    input  logic       if_req,
    input  logic       d_req,
    input  logic       last_owner,
    output logic [1:0] grant
);

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    // On contention the requester that did not win last time goes first
    always_comb begin
        grant = GNT_NONE;
        if (if_req && d_req) begin
            grant = (last_owner == OWN_DATA) ? GNT_FETCH : GNT_DATA;
        end else if (d_req) begin
            grant = GNT_DATA;
        end else if (if_req) begin
            grant = GNT_FETCH;
        end
    end
`else
    logic unused_last_owner;
    assign unused_last_owner = last_owner;

    // Data side always wins a tie
    always_comb begin
        grant = GNT_NONE;
        if (d_req) begin
            grant = GNT_DATA;
        end else if (if_req) begin
            grant = GNT_FETCH;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data shared memory port arbiter; MEM_ARBITER_ROUND_ROBIN_EN selects round-robin
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    output logic        o_if_ready,
    output logic        o_if_valid,
    output logic [31:0] o_if_rdata,
    output logic        o_if_err,
    input  logic        i_d_req,
    input  logic        i_d_wen,
    input  logic [31:0] i_d_addr,
    input  logic [31:0] i_d_wdata,
    input  logic [3:0]  i_d_mask,
    output logic        o_d_ready,
    output logic        o_d_valid,
    output logic [31:0] o_d_rdata,
    output logic        o_d_err,
    output logic        o_mem_req,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_mask,
    input  logic        i_mem_ready,
    input  logic        i_mem_valid,
    input  logic [31:0] i_mem_rdata
);

    localparam logic [1:0]  IDLE  = ARB_IDLE;
    localparam logic [1:0]  ISSUE = ARB_ISSUE;
    localparam logic [1:0]  WAIT  = ARB_WAIT;
    localparam logic        TIMEOUT_ON   = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state;
    logic        owner;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_mask;
    logic [31:0] wait_cnt;

    logic        if_valid;
    logic        if_err;
    logic [31:0] if_rdata;
    logic        d_valid;
    logic        d_err;
    logic [31:0] d_rdata;

    logic [1:0]  grant;
    logic        in_idle;
    logic        in_issue;
    logic        in_wait;
    logic        timeout_hit;
    logic        done_ok;
    logic        done_to;

    mem_arb_prio u_prio (
        .if_req     (i_if_req),
        .d_req      (i_d_req),
        .last_owner (owner),
        .grant      (grant)
    );

    assign in_idle  = (state == IDLE);
    assign in_issue = (state == ISSUE);
    assign in_wait  = (state == WAIT);

    // The last WAIT cycle before giving up is the one where the count hits TIMEOUT-1
    assign timeout_hit = TIMEOUT_ON && (wait_cnt == TIMEOUT_LAST);
    assign done_ok     = (in_issue && i_mem_ready && i_mem_valid) || (in_wait && i_mem_valid);
    assign done_to     = in_wait && !i_mem_valid && timeout_hit;

    // Ready is masked by reset so the outputs are quiet while reset is held
    assign o_if_ready  = !i_rst && in_idle && grant[0];
    assign o_d_ready   = !i_rst && in_idle && grant[1];

    assign o_mem_req   = in_issue;
    assign o_mem_wen   = req_wen;
    assign o_mem_addr  = req_addr;
    assign o_mem_wdata = req_wdata;
    assign o_mem_mask  = req_mask;

    assign o_if_valid  = if_valid;
    assign o_if_err    = if_err;
    assign o_if_rdata  = if_rdata;
    assign o_d_valid   = d_valid;
    assign o_d_err     = d_err;
    assign o_d_rdata   = d_rdata;

    // Transaction sequencing: capture the grant, hold the request, wait for the reply
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= IDLE;
            owner     <= OWN_FETCH;
            req_wen   <= 1'b0;
            req_addr  <= 32'd0;
            req_wdata <= 32'd0;
            req_mask  <= 4'd0;
            wait_cnt  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant[1]) begin
                        owner     <= OWN_DATA;
                        req_wen   <= i_d_wen;
                        req_addr  <= i_d_addr;
                        req_wdata <= i_d_wdata;
                        req_mask  <= i_d_mask;
                        state     <= ISSUE;
                    end else if (grant[0]) begin
                        owner     <= OWN_FETCH;
                        req_wen   <= 1'b0;
                        req_addr  <= i_if_addr;
                        req_wdata <= 32'd0;
                        req_mask  <= 4'b1111;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (i_mem_ready) begin
                        wait_cnt <= 32'd0;
                        state    <= i_mem_valid ? IDLE : WAIT;
                    end
                end
                WAIT: begin
                    if (done_ok || done_to) begin
                        state <= IDLE;
                    end else if (TIMEOUT_ON) begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Response pulses to the owner; rdata holds until the owner's next response
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            if_valid <= 1'b0;
            if_err   <= 1'b0;
            if_rdata <= 32'd0;
            d_valid  <= 1'b0;
            d_err    <= 1'b0;
            d_rdata  <= 32'd0;
        end else begin
            if_valid <= 1'b0;
            if_err   <= 1'b0;
            d_valid  <= 1'b0;
            d_err    <= 1'b0;
            if (done_ok || done_to) begin
                if (owner == OWN_DATA) begin
                    d_valid <= 1'b1;
                    d_err   <= done_to;
                    d_rdata <= (done_to || req_wen) ? 32'd0 : i_mem_rdata;
                end else begin
                    if_valid <= 1'b1;
                    if_err   <= done_to;
                    if_rdata <= done_to ? 32'd0 : i_mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed bench with cycle-level transaction model for mem_arbiter
module tb_mem_arbiter;

    localparam int T = 4;

    logic        i_clk, i_rst;
    logic        i_if_req;
    logic [31:0] i_if_addr;
    logic        o_if_ready, o_if_valid, o_if_err;
    logic [31:0] o_if_rdata;
    logic        i_d_req, i_d_wen;
    logic [31:0] i_d_addr, i_d_wdata;
    logic [3:0]  i_d_mask;
    logic        o_d_ready, o_d_valid, o_d_err;
    logic [31:0] o_d_rdata;
    logic        o_mem_req, o_mem_wen;
    logic [31:0] o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_mask;
    logic        i_mem_ready, i_mem_valid;
    logic [31:0] i_mem_rdata;

    mem_arbiter #(.TIMEOUT_CYCLES(T)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_ready(o_if_ready),
        .o_if_valid(o_if_valid), .o_if_rdata(o_if_rdata), .o_if_err(o_if_err),
        .i_d_req(i_d_req), .i_d_wen(i_d_wen), .i_d_addr(i_d_addr), .i_d_wdata(i_d_wdata),
        .i_d_mask(i_d_mask), .o_d_ready(o_d_ready), .o_d_valid(o_d_valid),
        .o_d_rdata(o_d_rdata), .o_d_err(o_d_err),
        .o_mem_req(o_mem_req), .o_mem_wen(o_mem_wen), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .o_mem_mask(o_mem_mask),
        .i_mem_ready(i_mem_ready), .i_mem_valid(i_mem_valid), .i_mem_rdata(i_mem_rdata)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
    } dreq_t;

    logic [31:0] fq[$];
    dreq_t       dq[$];
    logic        if_acc, d_acc;
    int          cfg_rd, cfg_vd;
    int          cyc = 0;
    int          n_cmp, n_fail;

    // model state
    logic        m_busy, m_owner, m_last, m_err, m_wen, pick;
    logic [31:0] m_addr, m_wdata, m_rdata, m_if_rdata, m_d_rdata;
    logic [3:0]  m_mask;
    int          m_grant, m_rd, m_resp;
    logic        e_if_v, e_d_v, e_if_e, e_d_e, e_if_r, e_d_r, e_mreq;

    // observations for literal checks
    byte         glog[$];
    int          gcyc[$];
    int          if_rdy_c, d_rdy_c, if_val_c, d_val_c, d_err_c;
    int          n_d_val, n_d_rdy, n_if_err;

    logic any_out;
    assign any_out = |{o_if_ready, o_if_valid, o_if_rdata, o_if_err, o_d_ready, o_d_valid,
                       o_d_rdata, o_d_err, o_mem_req, o_mem_wen, o_mem_addr, o_mem_wdata, o_mem_mask};

    function automatic logic [31:0] memfn(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'h0010_0073;
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    always @(posedge i_clk) cyc <= cyc + 1;

    // Requesters hold each queued request until accepted; memory answers with configured delays
    initial begin
        int age;
        int pend;
        logic [31:0] raddr;
        age = 0; pend = -1; raddr = 32'd0;
        i_if_req = 0; i_if_addr = 0; i_d_req = 0; i_d_wen = 0; i_d_addr = 0;
        i_d_wdata = 0; i_d_mask = 0; i_mem_ready = 0; i_mem_valid = 0;
        i_mem_rdata = 32'hDEAD_BEEF; if_acc = 0; d_acc = 0;
        forever begin
            @(posedge i_clk); #1;
            if (if_acc) begin void'(fq.pop_front()); if_acc = 0; end
            if (d_acc) begin void'(dq.pop_front()); d_acc = 0; end
            if (fq.size() != 0) begin i_if_req = 1; i_if_addr = fq[0]; end
            else begin i_if_req = 0; i_if_addr = 0; end
            if (dq.size() != 0) begin
                i_d_req = 1; i_d_wen = dq[0].wen; i_d_addr = dq[0].addr;
                i_d_wdata = dq[0].wdata; i_d_mask = dq[0].mask;
            end else begin
                i_d_req = 0; i_d_wen = 0; i_d_addr = 0; i_d_wdata = 0; i_d_mask = 0;
            end
            i_mem_ready = 0; i_mem_valid = 0; i_mem_rdata = 32'hDEAD_BEEF;
            if (i_rst) age = 0;
            if (pend >= 0) begin
                if (pend == 0) begin i_mem_valid = 1; i_mem_rdata = memfn(raddr); end
                pend--;
            end else if (o_mem_req) begin
                if (age == cfg_rd) begin
                    i_mem_ready = 1; age = 0; raddr = o_mem_addr;
                    if (cfg_vd == 0) begin i_mem_valid = 1; i_mem_rdata = memfn(raddr); end
                    else pend = cfg_vd - 1;
                end else begin
                    age++;
                end
            end
        end
    end

    // Transaction-level model and per-cycle comparison
    always @(negedge i_clk) begin
        if (i_rst) begin
            m_busy = 0; m_last = 0; m_if_rdata = 0; m_d_rdata = 0;
        end else begin
            e_if_v = 0; e_d_v = 0; e_if_e = 0; e_d_e = 0; e_if_r = 0; e_d_r = 0;
            if (m_busy && cyc == m_resp) begin
                m_busy = 0;
                if (m_owner) begin e_d_v = 1; e_d_e = m_err; m_d_rdata = m_rdata; end
                else begin e_if_v = 1; e_if_e = m_err; m_if_rdata = m_rdata; end
            end
            if (!m_busy && (i_if_req || i_d_req)) begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
                pick = (i_if_req && i_d_req) ? ~m_last : i_d_req;
`else
                pick = i_d_req;
`endif
                m_busy = 1; m_owner = pick; m_last = pick; m_grant = cyc; m_rd = cfg_rd;
                m_addr  = pick ? i_d_addr : i_if_addr;
                m_wen   = pick ? i_d_wen : 1'b0;
                m_wdata = i_d_wdata;
                m_mask  = pick ? i_d_mask : 4'b1111;
                if (T != 0 && cfg_vd > T) begin m_err = 1; m_resp = cyc + 2 + cfg_rd + T; end
                else begin m_err = 0; m_resp = cyc + 2 + cfg_rd + cfg_vd; end
                m_rdata = (m_err || m_wen) ? 32'd0 : memfn(m_addr);
                if (pick) e_d_r = 1; else e_if_r = 1;
            end
            e_mreq = m_busy && (cyc >= m_grant + 1) && (cyc <= m_grant + 1 + m_rd);
            chk("if_ready", o_if_ready, e_if_r);
            chk("d_ready", o_d_ready, e_d_r);
            chk("mem_req", o_mem_req, e_mreq);
            chk("if_valid", o_if_valid, e_if_v);
            chk("d_valid", o_d_valid, e_d_v);
            chk("if_err", o_if_err, e_if_e);
            chk("d_err", o_d_err, e_d_e);
            chk("if_rdata", o_if_rdata, m_if_rdata);
            chk("d_rdata", o_d_rdata, m_d_rdata);
            if (e_mreq) begin
                chk("mem_addr", o_mem_addr, m_addr);
                chk("mem_wen", o_mem_wen, m_wen);
                chk("mem_mask", o_mem_mask, m_mask);
                if (m_owner) chk("mem_wdata", o_mem_wdata, m_wdata);
            end
            if (o_if_ready) begin glog.push_back(8'h46); gcyc.push_back(cyc); if_rdy_c = cyc; if_acc = 1; end
            if (o_d_ready) begin glog.push_back(8'h44); gcyc.push_back(cyc); d_rdy_c = cyc; d_acc = 1; n_d_rdy++; end
            if (o_if_valid) if_val_c = cyc;
            if (o_if_err) n_if_err++;
            if (o_d_valid) begin d_val_c = cyc; n_d_val++; end
            if (o_d_err) d_err_c = cyc;
        end
    end

    task automatic wait_idle(input int maxc);
        int n;
        n = 0;
        while ((fq.size() != 0 || dq.size() != 0 || m_busy) && n < maxc) begin
            @(negedge i_clk); #1;
            n++;
        end
        if (n >= maxc) begin
            n_cmp++; n_fail++;
            $display("FAIL wait_idle: still busy after %0d cycles", maxc);
        end
        repeat (2) @(negedge i_clk);
    endtask

    task automatic push_d(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] mask);
        dreq_t r;
        r.wen = wen; r.addr = addr; r.wdata = wdata; r.mask = mask;
        dq.push_back(r);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        string ord;
        int base, v0, r0, n;
        n_cmp = 0; n_fail = 0; cfg_rd = 0; cfg_vd = 0;
        n_d_val = 0; n_d_rdy = 0; n_if_err = 0;
        if_rdy_c = 0; d_rdy_c = 0; if_val_c = 0; d_val_c = 0; d_err_c = 0;
        i_rst = 1;

        // reset state, ready masked while reset held
        repeat (3) @(negedge i_clk);
        chk("reset_outputs_zero", any_out, 0);
        fq.push_back(32'h0000_0100);
        repeat (2) @(negedge i_clk);
        chk("ready_masked_in_reset", {o_if_ready, o_d_ready}, 0);
        @(posedge i_clk); #3; i_rst = 0;

        // single fetch, zero-latency memory
        wait_idle(50);
        chk("fetch_latency", if_val_c - if_rdy_c, 2);
        chk("fetch_rdata", o_if_rdata, 32'h0010_0073);

        // contention: data first, then arbitration order
        base = glog.size();
        push_d(1'b0, 32'h0000_2000, 32'd0, 4'hf);
        push_d(1'b0, 32'h0000_2004, 32'd0, 4'hf);
        push_d(1'b0, 32'h0000_2008, 32'd0, 4'hf);
        fq.push_back(32'h0000_0004);
        fq.push_back(32'h0000_0008);
        fq.push_back(32'h0000_000c);
        wait_idle(100);
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        ord = "DFDFDF";
`else
        ord = "DDDFFF";
`endif
        for (int i = 0; i < 6; i++) chk("grant_order", 32'(glog[base + i]), 32'(ord[i]));
        chk("back_to_back_gap", gcyc[base + 1] - gcyc[base], 2);

        // store with memory ready delayed three cycles
        cfg_rd = 3; cfg_vd = 0;
        push_d(1'b1, 32'h0000_2003, 32'hAB00_0000, 4'b1000);
        wait_idle(50);
        chk("store_latency", d_val_c - d_rdy_c, 5);
        chk("store_rdata_zero", o_d_rdata, 32'd0);

        // load never answered in time: timeout, then stray response ignored
        cfg_rd = 0; cfg_vd = 10;
        v0 = n_d_val;
        push_d(1'b0, 32'h0000_3000, 32'd0, 4'hf);
        wait_idle(50);
        chk("timeout_latency", d_val_c - d_rdy_c, 6);
        chk("timeout_err_cycle", d_err_c - d_rdy_c, 6);
        repeat (12) @(negedge i_clk);
        chk("timeout_single_resp", n_d_val - v0, 1);

        // response in the last wait cycle beats the timeout
        cfg_rd = 1; cfg_vd = 4;
        fq.push_back(32'h0000_0040);
        wait_idle(50);
        chk("boundary_latency", if_val_c - if_rdy_c, 7);
        chk("boundary_rdata", o_if_rdata, 32'h0040_FFBF);
        chk("boundary_no_err", n_if_err, 0);

        // reset while waiting: no response, late memory reply ignored, next request normal
        cfg_rd = 0; cfg_vd = 6;
        v0 = n_d_val; r0 = n_d_rdy;
        push_d(1'b0, 32'h0000_4000, 32'd0, 4'hf);
        n = 0;
        while (n_d_rdy == r0 && n < 20) begin @(negedge i_clk); #1; n++; end
        if (n >= 20) begin
            n_cmp++; n_fail++;
            $display("FAIL reset_test_grant: no data grant within 20 cycles");
        end
        @(posedge i_clk);
        @(posedge i_clk); #3;
        i_rst = 1;
        #1;
        chk("reset_in_wait_zero", any_out, 0);
        repeat (2) @(posedge i_clk);
        #3; i_rst = 0;
        repeat (12) @(negedge i_clk);
        chk("reset_no_resp", n_d_val - v0, 0);
        cfg_rd = 0; cfg_vd = 0;
        fq.push_back(32'h0000_0100);
        wait_idle(50);
        chk("after_reset_latency", if_val_c - if_rdy_c, 2);
        chk("after_reset_rdata", o_if_rdata, 32'h0010_0073);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
